// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: RAW stall, redirect flush and saturating perf counters.
// Latency: stall/bubble/flush outputs are combinational in the hazard cycle; state is registered.
// Backpressure: raw holds PC and IF/ID and bubbles ID/EX; a redirect or FLUSH state overrides the stall.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_inst,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        ex_wen,
  input  logic        mem_wen,
  input  logic        wb_wen,
  input  logic        ex_redirect,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  state_t      r_state;
  logic        r_fcnt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic        w_rs1_hit;
  logic        w_rs2_hit;
  logic        w_raw;
  logic        w_in_flush;
  logic        w_stall;
  logic        w_flush;
  logic        w_unused_inst;

  assign w_opcode = id_inst[6:0];
  assign w_rs1    = id_inst[19:15];
  assign w_rs2    = id_inst[24:20];

  // Only the opcode and the two source fields matter for hazard detection.
  assign w_unused_inst = ^{id_inst[31:25], id_inst[14:7]};

  // Decode which source operands the instruction in ID actually reads.
  always_comb begin
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (w_opcode)
      7'b0110011: begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; end // R-type
      7'b0010011: begin w_rs1_used = 1'b1; end                    // OP-IMM
      7'b0000011: begin w_rs1_used = 1'b1; end                    // load
      7'b0100011: begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; end // store
      7'b1100011: begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; end // branch
      7'b1100111: begin w_rs1_used = 1'b1; end                    // jalr
      default:    begin w_rs1_used = 1'b0; w_rs2_used = 1'b0; end
    endcase
  end

  // RAW against any writing stage; WB counts because the regfile writes on the same edge. x0 never hazards.
  always_comb begin
    w_rs1_hit = 1'b0;
    w_rs2_hit = 1'b0;
    if (w_rs1_used && (w_rs1 != 5'd0)) begin
      w_rs1_hit = (ex_wen  && (ex_rd  == w_rs1)) ||
                  (mem_wen && (mem_rd == w_rs1)) ||
                  (wb_wen  && (wb_rd  == w_rs1));
    end
    if (w_rs2_used && (w_rs2 != 5'd0)) begin
      w_rs2_hit = (ex_wen  && (ex_rd  == w_rs2)) ||
                  (mem_wen && (mem_rd == w_rs2)) ||
                  (wb_wen  && (wb_rd  == w_rs2));
    end
  end

  assign w_raw      = w_rs1_hit || w_rs2_hit;
  assign w_in_flush = (r_state == ST_FLUSH);

  // A flush (redirect now or FLUSH state) always wins over a stall.
  assign w_flush = ex_redirect || w_in_flush;
  assign w_stall = w_raw && !ex_redirect && !w_in_flush;

  assign stall_if  = w_stall;
  assign stall_id  = w_stall;
  assign flush_id  = w_flush;
  assign bubble_ex = w_flush || w_raw;
  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // FSM: redirect -> FLUSH for two cycles after the redirect cycle, RAW -> STALL until it clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_fcnt  <= 1'b0;
    end else if (ex_redirect) begin
      r_state <= ST_FLUSH;
      r_fcnt  <= 1'b1;
    end else begin
      case (r_state)
        ST_RUN:   r_state <= w_raw ? ST_STALL : ST_RUN;
        ST_STALL: r_state <= w_raw ? ST_STALL : ST_RUN;
        ST_FLUSH: begin
          if (r_fcnt) begin
            r_fcnt <= 1'b0;
          end else begin
            r_state <= w_raw ? ST_STALL : ST_RUN;
          end
        end
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_flush && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expectation queue per step.
// Latency: outputs sampled 1 time unit after inputs change at the falling edge.
// Backpressure: none; stimulus is a fixed linear sequence.
module tb_pipeline_hazard_ctrl;

  localparam logic [31:0] NOP_I   = 32'h0000_0000;
  localparam logic [31:0] ADD_I   = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] LUI1_I  = 32'h0000_12B7; // lui  x5,1
  localparam logic [31:0] LUI8_I  = 32'h0000_82B7; // lui  x5,8 (rs1 field = 1)
  localparam logic [31:0] ADDI_I  = 32'h0010_0093; // addi x1,x0,1 (rs2 field = 1)
  localparam logic [31:0] SW_I    = 32'h0020_A023; // sw   x2,0(x1)
  localparam logic [31:0] JALR_I  = 32'h0003_8067; // jalr x0,0(x7)

  logic        clk;
  logic        rst;
  logic [31:0] id_inst;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_wen, mem_wen, wb_wen;
  logic        ex_redirect;
  logic        stall_if, stall_id, bubble_ex, flush_id;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [1:0]  st;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_scnt = 16'd0;
  logic [15:0] exp_fcnt = 16'd0;

  pipeline_hazard_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .id_inst    (id_inst),
    .ex_rd      (ex_rd),
    .mem_rd     (mem_rd),
    .wb_rd      (wb_rd),
    .ex_wen     (ex_wen),
    .mem_wen    (mem_wen),
    .wb_wen     (wb_wen),
    .ex_redirect(ex_redirect),
    .stall_if   (stall_if),
    .stall_id   (stall_id),
    .bubble_ex  (bubble_ex),
    .flush_id   (flush_id),
    .state      (state),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    id_inst = NOP_I;
    ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    ex_wen = 1'b0; mem_wen = 1'b0; wb_wen = 1'b0;
    ex_redirect = 1'b0;
  endtask

  // One cycle: drive at the falling edge, queue the expectation, pop and compare after settling.
  task automatic step(input string tag, input logic [31:0] inst,
                      input logic [4:0] erd, input logic ew,
                      input logic [4:0] mrd, input logic mw,
                      input logic [4:0] wrd, input logic ww,
                      input logic redir,
                      input logic e_stall, input logic e_bubble, input logic e_flush,
                      input logic [1:0] e_state);
    exp_t e;
    exp_t g;
    @(negedge clk);
    id_inst = inst;
    ex_rd = erd;  ex_wen = ew;
    mem_rd = mrd; mem_wen = mw;
    wb_rd = wrd;  wb_wen = ww;
    ex_redirect = redir;
    e.tag = tag; e.stall = e_stall; e.bubble = e_bubble; e.flush = e_flush;
    e.st = e_state; e.scnt = exp_scnt; e.fcnt = exp_fcnt;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk({g.tag, ".stall_if"},  {31'd0, stall_if},  {31'd0, g.stall});
    chk({g.tag, ".stall_id"},  {31'd0, stall_id},  {31'd0, g.stall});
    chk({g.tag, ".bubble_ex"}, {31'd0, bubble_ex}, {31'd0, g.bubble});
    chk({g.tag, ".flush_id"},  {31'd0, flush_id},  {31'd0, g.flush});
    chk({g.tag, ".state"},     {30'd0, state},     {30'd0, g.st});
    chk({g.tag, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, g.scnt});
    chk({g.tag, ".flush_cnt"}, {16'd0, flush_cnt}, {16'd0, g.fcnt});
    if (e_stall && exp_scnt != 16'hFFFF) exp_scnt = exp_scnt + 16'd1;
    if (e_flush && exp_fcnt != 16'hFFFF) exp_fcnt = exp_fcnt + 16'd1;
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    #2;
    chk("rst.state",     {30'd0, state},     32'd0);
    chk("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst.flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("rst.outs",      {28'd0, stall_if, stall_id, bubble_ex, flush_id}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //   tag    inst     exrd ew  mrd mw  wrd ww  rdr stl bub fls state
    step("idle", NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);

    // RAW on x1 moving EX -> MEM -> WB: three stall cycles.
    step("s1",   ADD_I,  1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00);
    step("s2",   ADD_I,  0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 2'b01);
    step("s3",   ADD_I,  0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 2'b01);
    step("s4",   ADD_I,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
    step("s5",   NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);

    // Single redirect: three-cycle wrong-path window.
    step("r1",   NOP_I,  0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2'b00);
    step("r2",   NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10);
    step("r3",   NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10);
    step("r4",   NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);

    // RAW coincident with redirect, RAW persisting through FLUSH then into STALL.
    step("c1",   ADD_I,  1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 2'b00);
    step("c2",   ADD_I,  1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10);
    step("c3",   ADD_I,  1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10);
    step("c4",   ADD_I,  1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2'b01);
    step("c5",   NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);

    // Back-to-back redirects: second one reloads the flush counter.
    step("d1",   NOP_I,  0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2'b00);
    step("d2",   NOP_I,  0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2'b10);
    step("d3",   NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10);
    step("d4",   NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10);
    step("d5",   NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);

    // x0, unused operands and disabled writes never hazard.
    step("z1",   LUI1_I, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    step("z2",   ADDI_I, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00);
    step("z3",   ADDI_I, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    step("z4",   LUI8_I, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    step("z5",   ADD_I,  1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00);

    // rs2 hazard on a store, rs1 hazard on jalr from WB.
    step("w1",   SW_I,   0, 0, 2, 1, 0, 0, 0, 1, 1, 0, 2'b00);
    step("w2",   NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
    step("j1",   JALR_I, 0, 0, 0, 0, 7, 1, 0, 1, 1, 0, 2'b00);
    step("j2",   NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
    step("j3",   NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);

    // Asynchronous reset while in FLUSH with fcnt = 1.
    step("p1",   NOP_I,  0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2'b00);
    @(negedge clk);
    drive_idle();
    #1;
    chk("p2.state_pre", {30'd0, state}, 32'd2);
    rst = 1'b1;
    #1;
    chk("p2.state_rst", {30'd0, state},     32'd0);
    chk("p2.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("p2.flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("p2.flush_id",  {31'd0, flush_id},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_scnt = 16'd0;
    exp_fcnt = 16'd0;
    step("p3",   NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);

    // Continuous stall long enough to saturate stall_cnt.
    @(negedge clk);
    id_inst = ADD_I; ex_rd = 5'd1; ex_wen = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sat.stall_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
    chk("sat.state",     {30'd0, state},     32'd1);
    repeat (5) @(posedge clk);
    exp_scnt = 16'hFFFF;
    step("sat2", ADD_I,  1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2'b01);
    step("sat3", NOP_I,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);

    chk("sb.empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset (`clk`, `rst`), with ports as listed in REQ-002..REQ-013.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 id_inst  input  32  instruction currently held in IF/ID.
REQ-005 ex_rd, mem_rd, wb_rd  input  5 each  destination register in ID/EX, EX/MEM, MEM/WB.
REQ-006 ex_wen, mem_wen, wb_wen  input  1 each  register-write enable for the matching stage.
REQ-007 ex_redirect  input  1  branch taken or jal/jalr resolved in EX this cycle.
REQ-008 stall_if  output  1  hold PC.
REQ-009 stall_id  output  1  hold IF/ID.
REQ-010 bubble_ex  output  1  load a NOP into ID/EX.
REQ-011 flush_id  output  1  replace IF/ID with a NOP.
REQ-012 state  output  2  debug: 00 RUN, 01 STALL, 10 FLUSH.
REQ-013 stall_cnt, flush_cnt  output  16 each  saturating performance counters.

Function
REQ-014 The block SHALL decode rs1 = id_inst[19:15] and rs2 = id_inst[24:20].
REQ-015 The block SHALL treat rs1 as used for opcodes 0110011, 0010011, 0000011, 0100011, 1100011 and 1100111.
REQ-016 The block SHALL treat rs2 as used for opcodes 0110011, 0100011 and 1100011.
REQ-017 The block SHALL treat rs1 and rs2 as unused for every other opcode (LUI, AUIPC, JAL, all-zero instruction).
REQ-018 raw SHALL be 1 when a used rsN is nonzero and equals the rd of any stage (EX, MEM, WB) whose wen is 1.
   - The design has no forwarding; the WB match counts because the register file writes on the same edge.
REQ-019 The block SHALL implement a three-state FSM (RUN, STALL, FLUSH), with a 1-bit flush counter fcnt.
REQ-020 ex_redirect SHALL have priority over raw in every state: the next state is FLUSH, fcnt <= 1.
REQ-021 RUN transitions:
   - raw and no redirect -> STALL.
   - otherwise stay in RUN.
REQ-022 STALL transitions:
   - raw and no redirect -> stay in STALL.
   - !raw -> RUN.
REQ-023 FLUSH transitions:
   - fcnt == 1 -> fcnt <= 0, stay in FLUSH.
   - fcnt == 0 -> RUN if !raw, else STALL.
   - A new ex_redirect while in FLUSH reloads fcnt <= 1.
REQ-024 Outputs SHALL be combinational from the current state and the inputs, acting in the same cycle as the hazard.
REQ-025 flush_id SHALL equal ex_redirect OR (state == FLUSH).
REQ-026 bubble_ex SHALL equal ex_redirect OR (state == FLUSH) OR raw.
REQ-027 stall_if and stall_id SHALL equal raw AND NOT ex_redirect AND NOT (state == FLUSH).
   - A flush always overrides a stall.
REQ-028 The wrong-path window SHALL therefore be exactly 3 cycles: the redirect cycle plus 2 FLUSH cycles.
REQ-029 stall_cnt SHALL increment by 1 on each edge where stall_if == 1.
REQ-030 flush_cnt SHALL increment by 1 on each edge where flush_id == 1.
REQ-031 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-032 A register number of 0 SHALL never cause raw, even when the stage's wen is 1.

Reset
REQ-033 While rst == 1, the FSM SHALL be in RUN with fcnt = 0, stall_cnt = 0 and flush_cnt = 0.
   - Outputs then follow only the combinational terms; with idle inputs they are all 0 and state = 00.
REQ-034 rst asserted mid-FLUSH or mid-STALL SHALL return the FSM to RUN immediately (asynchronously), and counters SHALL clear.
REQ-035 After rst deasserts, the first rising edge SHALL evaluate transitions from RUN.

Verification
REQ-036 Scenario: id_inst = add x3,x1,x2; ex_rd = 1, ex_wen = 1 -> stall_if = stall_id = bubble_ex = 1 that cycle, state = 01 next.
   - Then move x1 to MEM, then WB: the stall holds 3 cycles total.
   - When x1 clears: state = 00, stall_cnt = 3.
REQ-037 Scenario: ex_redirect = 1 for one cycle -> flush_id = bubble_ex = 1 for exactly 3 consecutive cycles, state = 10 for 2 cycles, flush_cnt = 3.
REQ-038 Scenario: raw and ex_redirect in the same cycle -> stall_if = 0, flush_id = 1, next state = 10.
REQ-039 Scenario: id_inst = lui x5,1 with ex_rd = 0 and ex_wen = 1; also addi x1,x0,1 with wb_rd = 0 -> no stall.
REQ-040 Scenario: rst pulse during FLUSH with fcnt = 1 -> state = 00 and counters = 0 before the next edge.
REQ-041 Scenario: force continuous stall for 70000 cycles -> stall_cnt holds 16'hFFFF.
